// File: rtl/mem_issue_queue.sv
// rtl/mem_issue_queue.sv - in-order memory issue queue feeding the MEM stage
// Entries wait for an address (exe) and, for stores, ROB commit before issue.
module mem_issue_queue #(
   parameter int DEPTH = 8
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       FLUSH,
   input  logic                       alloc_valid,
   input  logic [31:0]                alloc_instr_num,
   input  logic                       alloc_is_store,
   input  logic [5:0]                 alloc_ALU_Control,
   input  logic [5:0]                 alloc_RegWr_map,
   output logic                       alloc_ready,
   input  logic                       exe_valid,
   input  logic [31:0]                exe_instr_num,
   input  logic [31:0]                exe_ALU_result,
   input  logic [31:0]                exe_MemWriteData,
   input  logic                       commit_valid,
   input  logic [31:0]                commit_instr_num,
   input  logic                       mem_ready,
   output logic                       mem_valid,
   output logic [31:0]                ALU_result1_OUT,
   output logic [31:0]                MemWriteData1_OUT,
   output logic [5:0]                 ALU_Control1_OUT,
   output logic                       MemRead1_OUT,
   output logic                       MemWrite1_OUT,
   output logic [5:0]                 RegWr_map_OUT,
   output logic [31:0]                instr_num_OUT,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic          q_valid [DEPTH];
   logic [31:0]   q_tag   [DEPTH];
   logic          q_store [DEPTH];
   logic [5:0]    q_ctl   [DEPTH];
   logic [5:0]    q_map   [DEPTH];
   logic [31:0]   q_addr  [DEPTH];
   logic [31:0]   q_wdata [DEPTH];
   logic          q_rdy   [DEPTH];
   logic          q_cmt   [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;

   logic alloc_fire;
   logic alloc_exe_hit;
   logic alloc_cmt_hit;
   logic head_eligible;
   logic out_free;
   logic issue;

   always_comb begin
      alloc_ready   = (count != FULL_CNT);
      alloc_fire    = alloc_valid && alloc_ready && !FLUSH;
      alloc_exe_hit = exe_valid && (exe_instr_num == alloc_instr_num);
      alloc_cmt_hit = commit_valid && alloc_is_store && (commit_instr_num == alloc_instr_num);
      head_eligible = q_valid[head] && q_rdy[head] && (!q_store[head] || q_cmt[head]);
      out_free      = !mem_valid || mem_ready;
      issue         = head_eligible && out_free && !FLUSH;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_valid[i] <= 1'b0;
            q_tag[i]   <= '0;
            q_store[i] <= 1'b0;
            q_ctl[i]   <= '0;
            q_map[i]   <= '0;
            q_addr[i]  <= '0;
            q_wdata[i] <= '0;
            q_rdy[i]   <= 1'b0;
            q_cmt[i]   <= 1'b0;
         end
         head              <= '0;
         tail              <= '0;
         count             <= '0;
         mem_valid         <= 1'b0;
         ALU_result1_OUT   <= '0;
         MemWriteData1_OUT <= '0;
         ALU_Control1_OUT  <= '0;
         MemRead1_OUT      <= 1'b0;
         MemWrite1_OUT     <= 1'b0;
         RegWr_map_OUT     <= '0;
         instr_num_OUT     <= '0;
      end else if (FLUSH) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_valid[i] <= 1'b0;
         end
         head              <= '0;
         tail              <= '0;
         count             <= '0;
         mem_valid         <= 1'b0;
         ALU_result1_OUT   <= '0;
         MemWriteData1_OUT <= '0;
         ALU_Control1_OUT  <= '0;
         MemRead1_OUT      <= 1'b0;
         MemWrite1_OUT     <= 1'b0;
         RegWr_map_OUT     <= '0;
         instr_num_OUT     <= '0;
      end else begin
         // Tag-matched wakeups act on pre-edge contents; a popped head drops them.
         for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && exe_valid && (q_tag[i] == exe_instr_num)) begin
               q_addr[i]  <= exe_ALU_result;
               q_wdata[i] <= exe_MemWriteData;
               q_rdy[i]   <= 1'b1;
            end
            if (q_valid[i] && q_store[i] && commit_valid && (q_tag[i] == commit_instr_num)) begin
               q_cmt[i] <= 1'b1;
            end
         end

         if (alloc_fire) begin
            q_valid[tail] <= 1'b1;
            q_tag[tail]   <= alloc_instr_num;
            q_store[tail] <= alloc_is_store;
            q_ctl[tail]   <= alloc_ALU_Control;
            q_map[tail]   <= alloc_RegWr_map;
            q_addr[tail]  <= alloc_exe_hit ? exe_ALU_result : '0;
            q_wdata[tail] <= alloc_exe_hit ? exe_MemWriteData : '0;
            q_rdy[tail]   <= alloc_exe_hit;
            q_cmt[tail]   <= alloc_cmt_hit;
            tail          <= tail + PW'(1);
         end

         if (issue) begin
            mem_valid         <= 1'b1;
            ALU_result1_OUT   <= q_addr[head];
            MemWriteData1_OUT <= q_wdata[head];
            ALU_Control1_OUT  <= q_ctl[head];
            MemRead1_OUT      <= !q_store[head];
            MemWrite1_OUT     <= q_store[head];
            RegWr_map_OUT     <= q_map[head];
            instr_num_OUT     <= q_tag[head];
            q_valid[head]     <= 1'b0;
            head              <= head + PW'(1);
         end else if (out_free) begin
            mem_valid     <= 1'b0;
            MemRead1_OUT  <= 1'b0;
            MemWrite1_OUT <= 1'b0;
         end

         case ({alloc_fire, issue})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_issue_queue.sv
// tb/tb_mem_issue_queue.sv - directed bench with a queue-level reference model
// The model keeps entries as a SystemVerilog queue and is compared every cycle.
module tb_mem_issue_queue;
   localparam int DEPTH = 8;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        FLUSH = 1'b0;
   logic        alloc_valid = 1'b0;
   logic [31:0] alloc_instr_num = '0;
   logic        alloc_is_store = 1'b0;
   logic [5:0]  alloc_ALU_Control = '0;
   logic [5:0]  alloc_RegWr_map = '0;
   logic        alloc_ready;
   logic        exe_valid = 1'b0;
   logic [31:0] exe_instr_num = '0;
   logic [31:0] exe_ALU_result = '0;
   logic [31:0] exe_MemWriteData = '0;
   logic        commit_valid = 1'b0;
   logic [31:0] commit_instr_num = '0;
   logic        mem_ready = 1'b1;
   logic        mem_valid;
   logic [31:0] ALU_result1_OUT;
   logic [31:0] MemWriteData1_OUT;
   logic [5:0]  ALU_Control1_OUT;
   logic        MemRead1_OUT;
   logic        MemWrite1_OUT;
   logic [5:0]  RegWr_map_OUT;
   logic [31:0] instr_num_OUT;
   logic [3:0]  count;

   int total = 0;
   int bad = 0;

   always #5 CLK = ~CLK;

   mem_issue_queue #(.DEPTH(DEPTH)) dut (
      .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
      .alloc_valid(alloc_valid), .alloc_instr_num(alloc_instr_num),
      .alloc_is_store(alloc_is_store), .alloc_ALU_Control(alloc_ALU_Control),
      .alloc_RegWr_map(alloc_RegWr_map), .alloc_ready(alloc_ready),
      .exe_valid(exe_valid), .exe_instr_num(exe_instr_num),
      .exe_ALU_result(exe_ALU_result), .exe_MemWriteData(exe_MemWriteData),
      .commit_valid(commit_valid), .commit_instr_num(commit_instr_num),
      .mem_ready(mem_ready), .mem_valid(mem_valid),
      .ALU_result1_OUT(ALU_result1_OUT), .MemWriteData1_OUT(MemWriteData1_OUT),
      .ALU_Control1_OUT(ALU_Control1_OUT), .MemRead1_OUT(MemRead1_OUT),
      .MemWrite1_OUT(MemWrite1_OUT), .RegWr_map_OUT(RegWr_map_OUT),
      .instr_num_OUT(instr_num_OUT), .count(count)
   );

   typedef struct {
      logic [31:0] tag;
      logic        st;
      logic [5:0]  ctl;
      logic [5:0]  map;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        rdy;
      logic        cmt;
   } ent_t;

   ent_t        mq[$];
   logic        m_valid = 1'b0;
   logic [31:0] m_addr = '0;
   logic [31:0] m_wd = '0;
   logic [5:0]  m_ctl = '0;
   logic [5:0]  m_map = '0;
   logic [31:0] m_tag = '0;
   logic        m_rd = 1'b0;
   logic        m_wr = 1'b0;
   ent_t        m_head;
   ent_t        m_new;
   bit          m_free, m_elig, m_acc;

   logic [31:0] xfer_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_valid = 1'b0; m_addr = '0; m_wd = '0; m_ctl = '0;
      m_map = '0; m_tag = '0; m_rd = 1'b0; m_wr = 1'b0;
   endtask

   // Reference: the queue is a list in program order; issue always takes the front.
   always @(posedge CLK or posedge RESET) begin
      if (RESET || FLUSH) begin
         model_clear();
      end else begin
         m_free = !m_valid || mem_ready;
         m_elig = (mq.size() > 0) && mq[0].rdy && (!mq[0].st || mq[0].cmt);
         m_acc  = alloc_valid && (mq.size() < DEPTH);
         if (mq.size() > 0) m_head = mq[0];
         foreach (mq[i]) begin
            if (exe_valid && mq[i].tag == exe_instr_num) begin
               mq[i].addr = exe_ALU_result;
               mq[i].wd   = exe_MemWriteData;
               mq[i].rdy  = 1'b1;
            end
            if (commit_valid && mq[i].st && mq[i].tag == commit_instr_num) mq[i].cmt = 1'b1;
         end
         if (m_elig && m_free) begin
            m_valid = 1'b1; m_addr = m_head.addr; m_wd = m_head.wd;
            m_ctl = m_head.ctl; m_map = m_head.map; m_tag = m_head.tag;
            m_rd = !m_head.st; m_wr = m_head.st;
            void'(mq.pop_front());
         end else if (m_free) begin
            m_valid = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
         end
         if (m_acc) begin
            m_new.tag = alloc_instr_num; m_new.st = alloc_is_store;
            m_new.ctl = alloc_ALU_Control; m_new.map = alloc_RegWr_map;
            m_new.rdy = exe_valid && (exe_instr_num == alloc_instr_num);
            m_new.addr = exe_ALU_result; m_new.wd = exe_MemWriteData;
            m_new.cmt = commit_valid && alloc_is_store && (commit_instr_num == alloc_instr_num);
            mq.push_back(m_new);
         end
      end
   end

   always @(negedge CLK) begin
      chk("mem_valid", 32'(mem_valid), 32'(m_valid));
      chk("count", 32'(count), 32'(mq.size()));
      chk("alloc_ready", 32'(alloc_ready), 32'(mq.size() != DEPTH));
      chk("MemRead1_OUT", 32'(MemRead1_OUT), 32'(m_rd));
      chk("MemWrite1_OUT", 32'(MemWrite1_OUT), 32'(m_wr));
      if (m_valid) begin
         chk("ALU_result1_OUT", ALU_result1_OUT, m_addr);
         chk("MemWriteData1_OUT", MemWriteData1_OUT, m_wd);
         chk("ALU_Control1_OUT", 32'(ALU_Control1_OUT), 32'(m_ctl));
         chk("RegWr_map_OUT", 32'(RegWr_map_OUT), 32'(m_map));
         chk("instr_num_OUT", instr_num_OUT, m_tag);
      end
      if (mem_valid && mem_ready && !RESET) xfer_log.push_back(instr_num_OUT);
   end

   task automatic step();
      @(posedge CLK);
      #1;
      alloc_valid = 1'b0; exe_valid = 1'b0; commit_valid = 1'b0; FLUSH = 1'b0;
   endtask

   task automatic set_alloc(input logic [31:0] tag, input logic st);
      alloc_valid = 1'b1; alloc_instr_num = tag; alloc_is_store = st;
      alloc_ALU_Control = tag[5:0] ^ 6'h15; alloc_RegWr_map = tag[5:0] + 6'd1;
   endtask

   task automatic set_exe(input logic [31:0] tag, input logic [31:0] addr, input logic [31:0] wd);
      exe_valid = 1'b1; exe_instr_num = tag; exe_ALU_result = addr; exe_MemWriteData = wd;
   endtask

   task automatic set_commit(input logic [31:0] tag);
      commit_valid = 1'b1; commit_instr_num = tag;
   endtask

   task automatic do_flush();
      FLUSH = 1'b1;
      step();
   endtask

   initial begin
      #12;
      chk("reset mem_valid", 32'(mem_valid), 32'd0);
      chk("reset count", 32'(count), 32'd0);
      chk("reset alloc_ready", 32'(alloc_ready), 32'd1);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RESET = 1'b0;
      step();

      // Load with address captured in the same cycle it is allocated.
      mem_ready = 1'b1;
      set_alloc(32'd5, 1'b0); set_exe(32'd5, 32'h1000, 32'h0);
      step();
      step();
      chk("l5 mem_valid", 32'(mem_valid), 32'd1);
      chk("l5 addr", ALU_result1_OUT, 32'h1000);
      chk("l5 MemRead", 32'(MemRead1_OUT), 32'd1);
      chk("l5 count", 32'(count), 32'd0);
      step();

      // Store waits for commit.
      set_alloc(32'd7, 1'b1); set_exe(32'd7, 32'h2004, 32'hDEADBEEF);
      step();
      for (int i = 0; i < 10; i++) begin
         chk("st7 waits", 32'(mem_valid), 32'd0);
         step();
      end
      set_commit(32'd7);
      step();
      step();
      chk("st7 MemWrite", 32'(MemWrite1_OUT), 32'd1);
      chk("st7 data", MemWriteData1_OUT, 32'hDEADBEEF);
      chk("st7 addr", ALU_result1_OUT, 32'h2004);
      step();

      // Full queue, dropped alloc, out-of-order address arrival.
      do_flush();
      for (int t = 1; t <= 8; t++) begin
         set_alloc(32'(t), 1'b0);
         step();
      end
      chk("full count", 32'(count), 32'd8);
      chk("full alloc_ready", 32'(alloc_ready), 32'd0);
      set_alloc(32'd9, 1'b0);
      step();
      chk("drop count", 32'(count), 32'd8);
      set_exe(32'd99, 32'h99, 32'h0);
      step();
      xfer_log.delete();
      set_exe(32'd3, 32'h30, 32'h0); step();
      set_exe(32'd1, 32'h10, 32'h0); step();
      set_exe(32'd2, 32'h20, 32'h0); step();
      repeat (6) step();
      chk("ooo issued", 32'(xfer_log.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < xfer_log.size()) chk("ooo order", xfer_log[i], 32'(i + 1));
      end

      // Backpressure holds the output register.
      do_flush();
      mem_ready = 1'b0;
      set_alloc(32'd20, 1'b0); set_exe(32'd20, 32'h10, 32'h0); step();
      set_alloc(32'd21, 1'b0); set_exe(32'd21, 32'h20, 32'h0); step();
      for (int i = 0; i < 4; i++) begin
         chk("hold addr", ALU_result1_OUT, 32'h10);
         step();
      end
      mem_ready = 1'b1;
      step();
      chk("next addr", ALU_result1_OUT, 32'h20);
      step();

      // Pointer wrap with ordering preserved.
      do_flush();
      xfer_log.delete();
      for (int t = 30; t <= 35; t++) begin
         set_alloc(32'(t), 1'b0);
         step();
      end
      chk("wrap fill", 32'(count), 32'd6);
      for (int t = 30; t <= 33; t++) begin
         set_exe(32'(t), 32'(t) << 4, 32'h0);
         step();
      end
      repeat (4) step();
      chk("wrap popped", 32'(count), 32'd2);
      for (int t = 36; t <= 40; t++) begin
         set_alloc(32'(t), 1'b0);
         step();
      end
      chk("wrap count", 32'(count), 32'd7);
      for (int t = 34; t <= 40; t++) begin
         set_exe(32'(t), 32'(t) << 4, 32'h0);
         step();
      end
      repeat (4) step();
      chk("wrap issued", 32'(xfer_log.size()), 32'd11);
      for (int i = 0; i < 11; i++) begin
         if (i < xfer_log.size()) chk("wrap order", xfer_log[i], 32'(30 + i));
      end

      // Flush beats a same-cycle alloc.
      do_flush();
      mem_ready = 1'b0;
      for (int t = 50; t <= 55; t++) begin
         set_alloc(32'(t), 1'b0); set_exe(32'(t), 32'(t), 32'h0);
         step();
      end
      chk("pre-flush count", 32'(count), 32'd5);
      chk("pre-flush valid", 32'(mem_valid), 32'd1);
      FLUSH = 1'b1; set_alloc(32'd60, 1'b0);
      step();
      chk("flush count", 32'(count), 32'd0);
      chk("flush valid", 32'(mem_valid), 32'd0);
      chk("flush alloc_ready", 32'(alloc_ready), 32'd1);
      step();
      chk("flush alloc ignored", 32'(count), 32'd0);

      // Asynchronous reset in the middle of traffic.
      mem_ready = 1'b1;
      for (int t = 70; t <= 72; t++) begin
         set_alloc(32'(t), 1'b0); set_exe(32'(t), 32'h700 + 32'(t), 32'h0);
         step();
      end
      chk("pre-reset valid", 32'(mem_valid), 32'd1);
      RESET = 1'b1;
      #1;
      chk("async mem_valid", 32'(mem_valid), 32'd0);
      chk("async count", 32'(count), 32'd0);
      chk("async MemRead", 32'(MemRead1_OUT), 32'd0);
      chk("async addr", ALU_result1_OUT, 32'd0);
      chk("async tag", instr_num_OUT, 32'd0);
      chk("async alloc_ready", 32'(alloc_ready), 32'd1);
      step();
      step();
      RESET = 1'b0;
      step();
      step();
      chk("post-reset count", 32'(count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_issue_queue.md
MEM_ISSUE_QUEUE -- requirements
Module: mem_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of queue entries (power of two).
REQ-002 SHALL have ports: CLK  in  1  clock; RESET  in  1  reset (one clock; reset is asynchronous and active-high).
REQ-003 SHALL have: FLUSH  in  1  synchronous squash of all queued and output state.
REQ-004 SHALL have: alloc_valid in 1; alloc_instr_num in 32 (program-order tag); alloc_is_store in 1; alloc_ALU_Control in 6; alloc_RegWr_map in 6; alloc_ready out 1 (queue not full).
REQ-005 SHALL have: exe_valid in 1; exe_instr_num in 32; exe_ALU_result in 32 (address); exe_MemWriteData in 32 (store data).
REQ-006 SHALL have: commit_valid in 1; commit_instr_num in 32 (ROB permission for store).
REQ-007 SHALL have outputs to MEM stage: mem_valid 1; ALU_result1_OUT 32; MemWriteData1_OUT 32; ALU_Control1_OUT 6; MemRead1_OUT 1; MemWrite1_OUT 1; RegWr_map_OUT 6; instr_num_OUT 32; plus input mem_ready 1.
REQ-008 SHALL output count, width log2(DEPTH)+1, number of occupied entries.

Function
REQ-009 Queue SHALL be circular, head/tail pointers of log2(DEPTH) bits wrapping DEPTH-1 -> 0; entries leave strictly in allocation order.
REQ-010 Each entry SHALL hold valid, instr_num, is_store, ALU_Control, RegWr_map, addr, wdata, addr_ready, committed.
REQ-011 alloc_ready SHALL equal (count != DEPTH), combinational from registered count; alloc at full is dropped even if an issue occurs the same cycle.
REQ-012 Accepted alloc SHALL write tail entry with addr_ready=0, committed=0, then increment tail.
REQ-013 exe_valid SHALL set addr/wdata/addr_ready in every valid entry whose instr_num matches; no match -> ignored, no state change.
REQ-014 exe and alloc of same tag in same cycle SHALL allocate entry with addr_ready=1 and exe data captured.
REQ-015 commit_valid SHALL set committed in matching valid store entry; same-cycle alloc with matching tag SHALL allocate with committed=1; non-store or no match -> ignored.
REQ-016 Head SHALL be eligible when valid && addr_ready && (!is_store || committed); loads never wait for commit.
REQ-017 Output register SHALL be "free" when !mem_valid or mem_ready; transfer to MEM occurs at edge where mem_valid && mem_ready.
REQ-018 Eligible head with free output SHALL load the output register at the next edge and pop head (count-1, head+1); latency one cycle from eligibility (registered flags) to mem_valid.
REQ-019 Output not free SHALL hold all *_OUT values and mem_valid stable; head SHALL stay queued.
REQ-020 Loaded output: MemRead1_OUT = !is_store, MemWrite1_OUT = is_store, others copy entry; when mem_valid=0 MemRead1_OUT and MemWrite1_OUT SHALL be 0.
REQ-021 Transfer with no eligible head SHALL clear mem_valid, MemRead1_OUT, MemWrite1_OUT.
REQ-022 Simultaneous alloc and pop SHALL leave count unchanged; count SHALL never exceed DEPTH nor go below 0.
REQ-023 exe/commit updates targeting the head entry in the pop cycle SHALL be lost with that entry only if already popped; updates apply to pre-edge contents.
REQ-024 FLUSH SHALL take priority over alloc, exe, commit and issue: all entries invalid, pointers 0, count 0, mem_valid 0, at next edge.

Reset
REQ-025 RESET high SHALL immediately (asynchronously) clear all entry valid bits, head, tail, count and every output to 0; alloc_ready then reads 1.
REQ-026 RESET asserted mid-operation SHALL discard all in-flight entries and any held output; no transfer SHALL be reported while RESET is high.

Verification
REQ-027 Load alloc tag 5 with exe tag 5 addr 0x1000 same cycle, mem_ready=1 -> next edge mem_valid=1, ALU_result1_OUT=0x1000, MemRead1_OUT=1, count=0.
REQ-028 Store tag 7 addr 0x2004 data 0xDEADBEEF, no commit for 10 cycles -> mem_valid=0 throughout; commit tag 7 -> one edge later MemWrite1_OUT=1, MemWriteData1_OUT=0xDEADBEEF.
REQ-029 Allocate 8 loads without exe -> count=8, alloc_ready=0, 9th alloc dropped; exe tags out of order 3,1,2 -> issue order tag 1,2,3 only.
REQ-030 mem_ready=0 with two ready loads 0x10,0x20 -> output holds 0x10 for 4 cycles; mem_ready=1 -> 0x10 transfers, 0x20 appears next edge.
REQ-031 Fill 6 entries, pop 4, allocate 5 more -> tail wraps to 3, count=7, order preserved.
REQ-032 FLUSH with 5 entries and mem_valid=1, plus same-cycle alloc -> count=0, mem_valid=0, alloc ignored; RESET pulse mid-stream -> all outputs 0 immediately.
